// File: rtl/pipe_if_id_hazard_pkg.sv
// Shared pipeline constants for the IF/ID stage: NOP encoding, opcodes,
// instruction field positions and register-usage decode helpers.
package pipe_if_id_hazard_pkg;

  // addi x0,x0,0 -- what decode sees after reset or a squash
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  // U-type and JAL have no rs1; everything else reads it (or ignoring it is harmless)
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  // only R, S and B formats carry a real rs2; elsewhere bits 24:20 are immediate
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_S || op == OP_B);
  endfunction

endpackage

// File: rtl/hazard_detection_unit.sv
// Combinational load-use hazard check for the instruction held in IF/ID.
// A taken branch squashes the dependent instruction, so it cancels the stall.
module hazard_detection_unit
  import pipe_if_id_hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic                  valid,
  input  logic                  id_ex_mem_read,
  input  logic [4:0]            id_ex_rd,
  input  logic                  branch_taken,
  output logic                  stall
);

  logic [6:0] opc;
  logic [4:0] rs1, rs2;
  logic       rs1_hit, rs2_hit, hazard;

  assign opc = instruction[OPC_MSB:OPC_LSB];
  assign rs1 = instruction[RS1_MSB:RS1_LSB];
  assign rs2 = instruction[RS2_MSB:RS2_LSB];

  // immediate/funct/rd bits play no part in the dependency check
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[DATA_WIDTH-1:RS2_MSB+1], instruction[RS1_LSB-1:OPC_MSB+1]};

  // x0 is never a real dependency; squashed slots never stall
  always_comb begin
    rs1_hit = uses_rs1(opc) && (rs1 == id_ex_rd);
    rs2_hit = uses_rs2(opc) && (rs2 == id_ex_rd);
    hazard  = valid && id_ex_mem_read && (id_ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    stall   = hazard && !branch_taken;
  end

endmodule

// File: rtl/pipe_if_id_hazard.sv
// IF/ID pipeline register with load-use stall, branch squash and
// saturating stall/flush event counters.
module pipe_if_id_hazard
  import pipe_if_id_hazard_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] NOP_INSTR  = pipe_if_id_hazard_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pc_plus_4_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  input  logic                  id_ex_mem_read_i,
  input  logic [4:0]            id_ex_rd_i,
  input  logic                  branch_taken_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus_4_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  valid_o,
  output logic                  pc_write_o,
  output logic                  bubble_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus_4;
    logic [DATA_WIDTH-1:0] instr;
  } if_id_t;

  if_id_t q, d_in;
  logic   stall;

  assign d_in = '{pc: pc_i, pc_plus_4: pc_plus_4_i, instr: instruction_i};

  hazard_detection_unit #(.DATA_WIDTH(DATA_WIDTH)) u_hdu (
    .instruction    (q.instr),
    .valid          (valid_o),
    .id_ex_mem_read (id_ex_mem_read_i),
    .id_ex_rd       (id_ex_rd_i),
    .branch_taken   (branch_taken_i),
    .stall          (stall)
  );

  assign pc_write_o    = !stall;
  assign bubble_o      = stall;
  assign pc_o          = q.pc;
  assign pc_plus_4_o   = q.pc_plus_4;
  assign instruction_o = q.instr;

  // payload register: flush squashes, stall holds, otherwise advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '{pc: '0, pc_plus_4: '0, instr: DATA_WIDTH'(NOP_INSTR)};
      valid_o <= 1'b0;
    end else if (branch_taken_i) begin
      q       <= '{pc: pc_i, pc_plus_4: pc_plus_4_i, instr: DATA_WIDTH'(NOP_INSTR)};
      valid_o <= 1'b0;
    end else if (!stall) begin
      q       <= d_in;
      valid_o <= 1'b1;
    end
  end

  // saturating event counters; flush and stall are mutually exclusive per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (branch_taken_i && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
      if (stall && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_if_id_hazard.sv
// Directed, table-driven bench for pipe_if_id_hazard.
module tb_pipe_if_id_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i, pc_plus_4_i, instruction_i;
  logic        id_ex_mem_read_i;
  logic [4:0]  id_ex_rd_i;
  logic        branch_taken_i;
  logic [31:0] pc_o, pc_plus_4_o, instruction_o;
  logic        valid_o, pc_write_o, bubble_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  pipe_if_id_hazard dut (
    .clk              (clk),
    .reset            (reset),
    .pc_i             (pc_i),
    .pc_plus_4_i      (pc_plus_4_i),
    .instruction_i    (instruction_i),
    .id_ex_mem_read_i (id_ex_mem_read_i),
    .id_ex_rd_i       (id_ex_rd_i),
    .branch_taken_i   (branch_taken_i),
    .pc_o             (pc_o),
    .pc_plus_4_o      (pc_plus_4_o),
    .instruction_o    (instruction_o),
    .valid_o          (valid_o),
    .pc_write_o       (pc_write_o),
    .bubble_o         (bubble_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rd;
    logic        br;
    logic        e_pw;      // pc_write before the edge
    logic        chk_pc;    // pc is don't-care after a flush
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [15:0] e_sc;
    logic [15:0] e_fc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] instr, logic mr, logic [4:0] rd,
                              logic br, logic e_pw, logic chk_pc, logic [31:0] e_pc,
                              logic [31:0] e_instr, logic e_valid, logic [15:0] e_sc,
                              logic [15:0] e_fc);
    vec_t v;
    v.pc = pc; v.instr = instr; v.mr = mr; v.rd = rd; v.br = br; v.e_pw = e_pw;
    v.chk_pc = chk_pc; v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
    v.e_sc = e_sc; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic mr,
                       input logic [4:0] rd, input logic br);
    pc_i = pc; pc_plus_4_i = pc + 32'd4; instruction_i = instr;
    id_ex_mem_read_i = mr; id_ex_rd_i = rd; branch_taken_i = br;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    drive(32'h0, NOP, 1'b0, 5'd0, 1'b0);
    do_reset();

    // reset state
    chk("rst_instr", instruction_o, NOP);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc4", pc_plus_4_o, 32'd0);
    chk("rst_scnt", {16'd0, stall_cnt_o}, 32'd0);
    chk("rst_fcnt", {16'd0, flush_cnt_o}, 32'd0);
    chk("rst_pcw", {31'd0, pc_write_o}, 32'd1);

    //              pc        instr         mr    rd    br   pw  chkpc e_pc      e_instr       v   sc  fc
    tbl[0]  = mk(32'h100, 32'h00208033, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h00208033, 1'b1, 16'd0, 16'd0);
    tbl[1]  = mk(32'h104, 32'h00308133, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h00308133, 1'b1, 16'd0, 16'd0);
    // add x2,x1,x3 held, load writes x3 -> stall via rs2
    tbl[2]  = mk(32'h108, 32'h00310093, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 32'h104, 32'h00308133, 1'b1, 16'd1, 16'd0);
    tbl[3]  = mk(32'h108, 32'h00310093, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 32'h108, 32'h00310093, 1'b1, 16'd1, 16'd0);
    // addi x1,x2,3: rs2 field is an immediate -> no stall
    tbl[4]  = mk(32'h10C, 32'h0040A183, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 32'h10C, 32'h0040A183, 1'b1, 16'd1, 16'd0);
    // lw x3,4(x1) held, load writes x1 -> stall via rs1
    tbl[5]  = mk(32'h110, 32'h00000033, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'h10C, 32'h0040A183, 1'b1, 16'd2, 16'd0);
    tbl[6]  = mk(32'h110, 32'h00000033, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 32'h110, 32'h00000033, 1'b1, 16'd2, 16'd0);
    // add x0,x0,x0 held, load rd=x0 -> never a hazard
    tbl[7]  = mk(32'h114, 32'h000280B7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 32'h114, 32'h000280B7, 1'b1, 16'd2, 16'd0);
    // lui with rs1 field = 5, load rd=5 -> no stall
    tbl[8]  = mk(32'h118, 32'h00308133, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 32'h118, 32'h00308133, 1'b1, 16'd2, 16'd0);
    // hazard on x1 plus taken branch -> flush wins
    tbl[9]  = mk(32'h11C, 32'h12345678, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0,   NOP,          1'b0, 16'd2, 16'd1);
    // squashed slot never stalls
    tbl[10] = mk(32'h120, 32'h00208033, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 32'h120, 32'h00208033, 1'b1, 16'd2, 16'd1);
    tbl[11] = mk(32'h124, 32'h00308133, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,   NOP,          1'b0, 16'd2, 16'd2);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].pc, tbl[i].instr, tbl[i].mr, tbl[i].rd, tbl[i].br);
      #1;
      chk($sformatf("v%0d_pcw", i), {31'd0, pc_write_o}, {31'd0, tbl[i].e_pw});
      chk($sformatf("v%0d_bub", i), {31'd0, bubble_o}, {31'd0, ~tbl[i].e_pw});
      @(posedge clk);
      #1;
      if (tbl[i].chk_pc) begin
        chk($sformatf("v%0d_pc", i), pc_o, tbl[i].e_pc);
        chk($sformatf("v%0d_pc4", i), pc_plus_4_o, tbl[i].e_pc + 32'd4);
      end
      chk($sformatf("v%0d_instr", i), instruction_o, tbl[i].e_instr);
      chk($sformatf("v%0d_valid", i), {31'd0, valid_o}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_scnt", i), {16'd0, stall_cnt_o}, {16'd0, tbl[i].e_sc});
      chk($sformatf("v%0d_fcnt", i), {16'd0, flush_cnt_o}, {16'd0, tbl[i].e_fc});
    end

    // stall counter saturation: hold a load-use hazard continuously
    @(negedge clk);
    drive(32'h0, NOP, 1'b0, 5'd0, 1'b0);
    do_reset();
    drive(32'h200, 32'h00308133, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive(32'h204, 32'h00208033, 1'b1, 5'd3, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, stall_cnt_o}, 32'h0000FFFE);
    @(posedge clk); #1;
    chk("sat_ffff", {16'd0, stall_cnt_o}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, stall_cnt_o}, 32'h0000FFFF);
    chk("sat_instr_held", instruction_o, 32'h00308133);
    chk("sat_pc_held", pc_o, 32'h200);
    chk("sat_fcnt", {16'd0, flush_cnt_o}, 32'd0);

    // asynchronous reset between edges, mid-stall
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_instr", instruction_o, NOP);
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_scnt", {16'd0, stall_cnt_o}, 32'd0);
    chk("arst_pcw", {31'd0, pc_write_o}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_if_id_hazard.md
Name: pipe_if_id_hazard

Overview:
IF/ID pipeline register with integrated load-use hazard detection and branch flush. It sits between instruction fetch and decode, directly upstream of the ID/EX register.
- Holds the fetched instruction and PCs for one cycle.
- Stalls fetch and requests a decode bubble on a load-use hazard.
- Squashes the held instruction when EX resolves a taken branch or jump.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
DATA_WIDTH, 32, width of pc, pc_plus_4 and instruction paths
CNT_WIDTH, 16, width of the stall and flush event counters
NOP_INSTR, 32'h00000013, encoding inserted on flush/reset (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pc_i  input  DATA_WIDTH  PC of the instruction being fetched
pc_plus_4_i  input  DATA_WIDTH  pc_i + 4 from fetch
instruction_i  input  DATA_WIDTH  fetched instruction word
id_ex_mem_read_i  input  1  instruction currently in ID/EX is a load
id_ex_rd_i  input  5  destination register of the instruction in ID/EX
branch_taken_i  input  1  EX resolved a taken branch or jump this cycle
pc_o  output  DATA_WIDTH  registered PC
pc_plus_4_o  output  DATA_WIDTH  registered pc_plus_4
instruction_o  output  DATA_WIDTH  registered instruction, to decode
valid_o  output  1  instruction_o is a real (non-squashed) instruction
pc_write_o  output  1  0 = fetch must hold its PC this cycle
bubble_o  output  1  1 = decode must drive zero control/alu_operation into ID/EX
stall_cnt_o  output  CNT_WIDTH  number of stall cycles, saturating
flush_cnt_o  output  CNT_WIDTH  number of flush events, saturating

Behaviour:
- Reset (reset==0, async): pc_o=0, pc_plus_4_o=0, instruction_o=NOP_INSTR, valid_o=0, stall_cnt_o=0, flush_cnt_o=0. Reset asserted mid-stall or mid-flush wins immediately.
- Field decode of instruction_o:
  - rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
  - uses_rs1 = 1 except for opcodes 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL).
  - uses_rs2 = 1 only for opcodes 0110011 (R), 0100011 (S) and 1100011 (B).
- Hazard (combinational):
  - hazard = valid_o & id_ex_mem_read_i & (id_ex_rd_i != 0) & ((uses_rs1 & rs1 == id_ex_rd_i) | (uses_rs2 & rs2 == id_ex_rd_i)).
  - stall = hazard & ~branch_taken_i.
  - pc_write_o = ~stall. bubble_o = stall.
- Register update on rising clk, in priority order:
  1. branch_taken_i=1 (flush): instruction_o<=NOP_INSTR, valid_o<=0, pc_o/pc_plus_4_o<=inputs (don't-care), flush_cnt_o++. Flush beats stall.
  2. stall=1: all data outputs and valid_o hold; stall_cnt_o++.
  3. otherwise: load pc_i, pc_plus_4_i, instruction_i; valid_o<=1.
- Latency: 1 cycle from input to output when not stalled.
- A stall lasts exactly 1 cycle. The next cycle, ID/EX holds the bubble (mem_read=0), so the hazard clears.
- Counters saturate at all-ones and never wrap. Each counter increments at most once per cycle.
- A squashed instruction (valid_o=0) never raises a hazard.
- No X propagation: every output has a defined reset value.

Decomposition:
- Shared package, pipeline constants:
  - NOP_INSTR.
  - Opcode localparams: OP_R, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_LOAD.
  - Field bit positions for rs1, rs2 and opcode.
- Sub-module hazard_detection_unit: purely combinational.
  - Inputs: instruction_o, valid_o, id_ex_mem_read_i, id_ex_rd_i, branch_taken_i.
  - Outputs: stall.
  - Lets the same logic be reused by a future forwarding-aware variant.
- The top level holds the registers and counters.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> instruction_o=32'h00000013, valid_o=0, pc_o=0, both counters=0, pc_write_o=1.
- Normal flow: pc_i=0x100, instruction_i=0x00208033 (add x0,x1,x2), no hazard -> next cycle pc_o=0x100, instruction_o=0x00208033, valid_o=1.
- Load-use: instruction_o=0x00308133 (add x2,x1,x3), id_ex_mem_read_i=1, id_ex_rd_i=3 -> pc_write_o=0, bubble_o=1, outputs held, stall_cnt_o=1. Next cycle with mem_read=0, advance.
- Rs2 ignored: instruction_o=0x00310093 (addi x1,x2,3), id_ex_rd_i=3, mem_read=1 -> no stall (I-type doesn't use rs2). id_ex_rd_i=0 -> never stalls.
- Flush beats stall: load-use hazard plus branch_taken_i=1 in the same cycle -> pc_write_o=1, next instruction_o=NOP, valid_o=0, flush_cnt_o=1, stall_cnt_o unchanged.
- Saturation/async reset: force 65536 stall cycles -> stall_cnt_o stays 0xFFFF. Drop reset between clock edges -> outputs clear immediately.
